calc_ctrl: RTL and testbench
============================

// Module: calc_ctrl
// PURPOSE
//  Consumes debounced key events (flag pulse + 4-bit code) from the matrix key scanner and runs the calculator.
//  Handles operand entry, operator latch, '=' evaluation and clear; outputs a binary value plus sign/error to the display stage.
//  Keys: 0-9 digits, 10 '+', 11 '-', 12 '*', 13 '/', 14 '=', 15 'C' (clear).
// PARAMETERS
//  DIGITS  4   max decimal digits per operand; MAX_OPND = 10**DIGITS-1 (9999)
//  OP_W    14  operand width, must hold MAX_OPND
//  RES_W   28  result magnitude width, = 2*OP_W
// PORTS
//  clk        in   1      system clock
//  rst        in   1      asynchronous, active-high reset; one clock domain only
//  key_flag   in   1      1-cycle pulse, key_data valid in same cycle
//  key_data   in   4      key code
//  disp_val   out  RES_W  magnitude to display
//  disp_neg   out  1      result is negative (RES state only)
//  err        out  1      divide-by-zero indicator, held until 'C'
//  busy       out  1      evaluation in progress; keys other than 'C' ignored
//  res_valid  out  1      1-cycle pulse when result written
// BEHAVIOUR
//  Reset: state=ENT_A, A=B=0, op=ADD, all outputs 0.
//  States: ENT_A -> (op key) OP_WAIT -> (digit) ENT_B -> ('=') CALC -> RES; ERR on /0.
//  Digit in ENT_A/ENT_B: X <= X*10+d. Ignored if X already has DIGITS digits (X*10+d > MAX_OPND).
//  Op key: ENT_A latches op -> OP_WAIT. In OP_WAIT a new op key overwrites op. In ENT_B op keys are ignored.
//  '=' accepted only in ENT_B; ignored in ENT_A/OP_WAIT/RES/ERR.
//  Digit in RES: A<=d, B<=0 -> ENT_A (new calculation).
//  Display: ENT_A/OP_WAIT show A; ENT_B shows B; RES shows result; ERR shows 0, err=1.
//  Arithmetic: ADD A+B; SUB: A>=B ? A-B : B-A with disp_neg=1; MUL full RES_W product; DIV integer quotient (truncate).
//  Latency ('=' flag at cycle N): +,-,* -> result and res_valid at N+2 (1 CALC cycle).
//   '/' -> N+2+OP_W; busy=1 from N+1 until the res_valid cycle.
//  B==0 with '/': CALC -> ERR in 1 cycle, no divider start, no res_valid.
//  'C' (15) in any state, including CALC: abort divider, return to reset values (1 cycle).
//  key_flag while busy (non-'C'): dropped, not queued.
//  rst asserted mid-calculation: immediate return to reset values, divider state cleared.
// CONFIGURATION
//  CALC_CHAIN_EN defined: op key in RES with disp_neg=0 and result<=MAX_OPND loads A<=result, latches op -> OP_WAIT.
//   Otherwise the op key is ignored.
//  Not defined: op keys in RES are ignored; only digit or 'C' leaves RES.
// STRUCTURE
//  calc_pkg: key code constants (KEY_ADD=10..KEY_CLR=15), op encoding (ADD/SUB/MUL/DIV), state encoding, MAX_OPND.
//  Sub-module calc_div: restoring divider, OP_W iterations, start/done handshake.
//   start is a 1-cycle pulse; done is a 1-cycle pulse with quotient; abort input clears it.
//  Multiplier: inferred combinational multiply, registered in CALC.
// TESTING
//  keys 1,+,9,= -> res_valid 2 cycles after '=' flag; disp_val=10, disp_neg=0
//  keys 1,-,9,= -> disp_val=8, disp_neg=1; keys 9,-,1,= -> disp_val=8, disp_neg=0
//  9,9,9,9,9,*,9,9,9,9,= -> fifth digit ignored, disp_val=99980001
//  9,/,2,= -> busy high OP_W+1 cycles, disp_val=4
//  7,/,0,= -> err=1, no res_valid; then 'C' -> err=0, disp_val=0
//  9,/,1,= then 'C' while busy -> divider aborted, no res_valid, disp_val=0
//  CALC_CHAIN_EN: 2,+,3,=,*,4,= -> 20; without the macro, '*' is ignored and digit 4 starts A=4
//  rst asserted during divider -> outputs 0 in same cycle, next '=' ignored until new entry

Source files
------------

// File: rtl/calc_pkg.sv
// Shared sizes, key codes, operator and state encodings for the calculator controller.
package calc_pkg;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned OP_W   = 14;
  localparam int unsigned RES_W  = 2 * OP_W;
  localparam logic [OP_W-1:0] MAX_OPND = OP_W'(10**DIGITS - 1);

  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_SUB = 4'd11;
  localparam logic [3:0] KEY_MUL = 4'd12;
  localparam logic [3:0] KEY_DIV = 4'd13;
  localparam logic [3:0] KEY_EQ  = 4'd14;
  localparam logic [3:0] KEY_CLR = 4'd15;

  typedef enum logic [1:0] {
    OP_ADD,
    OP_SUB,
    OP_MUL,
    OP_DIV
  } op_e;

  // ST_DIV_RUN is the multi-cycle tail of the calculation while the divider iterates.
  typedef enum logic [2:0] {
    ST_ENT_A,
    ST_OP_WAIT,
    ST_ENT_B,
    ST_CALC,
    ST_DIV_RUN,
    ST_RES,
    ST_ERR
  } state_e;

  function automatic op_e key_to_op(input logic [3:0] key);
    case (key)
      KEY_SUB: return OP_SUB;
      KEY_MUL: return OP_MUL;
      KEY_DIV: return OP_DIV;
      default: return OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/calc_if.sv
// Key-event input and display-stage output bundle of the calculator controller.
interface calc_if;
  import calc_pkg::*;

  logic             key_flag;
  logic [3:0]       key_data;
  logic [RES_W-1:0] disp_val;
  logic             disp_neg;
  logic             err;
  logic             busy;
  logic             res_valid;

  modport master (
    output key_flag, key_data,
    input  disp_val, disp_neg, err, busy, res_valid
  );

  modport slave (
    input  key_flag, key_data,
    output disp_val, disp_neg, err, busy, res_valid
  );

endinterface

// File: rtl/calc_div.sv
// Restoring divider: W iterations, first one on the start edge; done pulses with the quotient.
module calc_div
  import calc_pkg::*;
#(
  parameter int unsigned W = OP_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient
);

  localparam int unsigned CW = $clog2(W);

  logic [W-1:0]   rem;
  logic [W-1:0]   quo;
  logic [W-1:0]   dsr;
  logic [CW-1:0]  cnt;
  logic           run;
  logic [2*W-1:0] first_step;
  logic [2*W-1:0] next_step;

  // One shift-subtract step; returns {remainder, quotient/dividend shift register}.
  function automatic logic [2*W-1:0] div_step(input logic [W-1:0] r,
                                              input logic [W-1:0] q,
                                              input logic [W-1:0] d);
    logic [W:0] sh;
    sh = {r, q[W-1]};
    if (sh >= {1'b0, d}) begin
      sh = sh - {1'b0, d};
      return {sh[W-1:0], q[W-2:0], 1'b1};
    end
    return {sh[W-1:0], q[W-2:0], 1'b0};
  endfunction

  assign first_step = div_step('0, dividend, divisor);
  assign next_step  = div_step(rem, quo, dsr);
  assign quotient   = quo;

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem  <= '0;
      quo  <= '0;
      dsr  <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        rem <= '0;
        quo <= '0;
        cnt <= '0;
        run <= 1'b0;
      end else if (start) begin
        {rem, quo} <= first_step;
        dsr        <= divisor;
        cnt        <= CW'(W - 1);
        run        <= 1'b1;
      end else if (run) begin
        {rem, quo} <= next_step;
        cnt        <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/calc_ctrl.sv
// Calculator controller: operand entry, operator latch, evaluation and clear.
// Optional build macro CALC_CHAIN_EN lets an operator key in RES reuse the result as A.
module calc_ctrl
  import calc_pkg::*;
(
  input logic   clk,
  input logic   rst,
  calc_if.slave bus
);

  localparam int unsigned ENT_W = OP_W + 4;

  state_e           state, state_next;
  op_e              op, op_next;
  logic [OP_W-1:0]  a, a_next;
  logic [OP_W-1:0]  b, b_next;
  logic [RES_W-1:0] result, result_next;
  logic             neg, neg_next;
  logic             res_valid, res_valid_next;

  logic             key_digit, key_op, key_eq, key_clr;
  logic [ENT_W-1:0] a_ent, b_ent;
  logic [RES_W-1:0] arith;
  logic             arith_neg;
  logic             div_start, div_done;
  logic [OP_W-1:0]  quotient;

  assign key_digit = bus.key_flag && (bus.key_data <= 4'd9);
  assign key_op    = bus.key_flag && (bus.key_data >= KEY_ADD) && (bus.key_data <= KEY_DIV);
  assign key_eq    = bus.key_flag && (bus.key_data == KEY_EQ);
  assign key_clr   = bus.key_flag && (bus.key_data == KEY_CLR);

  // Candidate operand after appending the digit; wide enough to detect a fifth digit.
  assign a_ent = ENT_W'(a) * ENT_W'(10) + ENT_W'(bus.key_data);
  assign b_ent = ENT_W'(b) * ENT_W'(10) + ENT_W'(bus.key_data);

  always_comb begin
    arith     = '0;
    arith_neg = 1'b0;
    case (op)
      OP_ADD: arith = RES_W'(a) + RES_W'(b);
      OP_SUB: begin
        if (a >= b) begin
          arith = RES_W'(a - b);
        end else begin
          arith     = RES_W'(b - a);
          arith_neg = 1'b1;
        end
      end
      OP_MUL: arith = RES_W'(a) * RES_W'(b);
      default: arith = '0;
    endcase
  end

  calc_div #(.W(OP_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .abort    (key_clr),
    .dividend (a),
    .divisor  (b),
    .done     (div_done),
    .quotient (quotient)
  );

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next     = state;
    op_next        = op;
    a_next         = a;
    b_next         = b;
    result_next    = result;
    neg_next       = neg;
    res_valid_next = 1'b0;
    div_start      = 1'b0;

    case (state)
      ST_ENT_A: begin
        if (key_digit) begin
          if (a_ent <= ENT_W'(MAX_OPND)) a_next = a_ent[OP_W-1:0];
        end else if (key_op) begin
          op_next    = key_to_op(bus.key_data);
          state_next = ST_OP_WAIT;
        end
      end
      ST_OP_WAIT: begin
        if (key_digit) begin
          b_next     = OP_W'(bus.key_data);
          state_next = ST_ENT_B;
        end else if (key_op) begin
          op_next = key_to_op(bus.key_data);
        end
      end
      ST_ENT_B: begin
        if (key_digit) begin
          if (b_ent <= ENT_W'(MAX_OPND)) b_next = b_ent[OP_W-1:0];
        end else if (key_eq) begin
          state_next = ST_CALC;
        end
      end
      ST_CALC: begin
        if (op == OP_DIV) begin
          if (b == '0) begin
            state_next = ST_ERR;
          end else begin
            div_start  = 1'b1;
            state_next = ST_DIV_RUN;
          end
        end else begin
          result_next    = arith;
          neg_next       = arith_neg;
          res_valid_next = 1'b1;
          state_next     = ST_RES;
        end
      end
      ST_DIV_RUN: begin
        if (div_done) begin
          result_next    = RES_W'(quotient);
          neg_next       = 1'b0;
          res_valid_next = 1'b1;
          state_next     = ST_RES;
        end
      end
      ST_RES: begin
        if (key_digit) begin
          a_next     = OP_W'(bus.key_data);
          b_next     = '0;
          state_next = ST_ENT_A;
        end
`ifdef CALC_CHAIN_EN
        else if (key_op && !neg && (result <= RES_W'(MAX_OPND))) begin
          a_next     = result[OP_W-1:0];
          b_next     = '0;
          op_next    = key_to_op(bus.key_data);
          state_next = ST_OP_WAIT;
        end
`endif
      end
      default: ;
    endcase

    // Clear wins over everything, including an evaluation in flight.
    if (key_clr) begin
      state_next     = ST_ENT_A;
      op_next        = OP_ADD;
      a_next         = '0;
      b_next         = '0;
      result_next    = '0;
      neg_next       = 1'b0;
      res_valid_next = 1'b0;
      div_start      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_ENT_A;
      op        <= OP_ADD;
      a         <= '0;
      b         <= '0;
      result    <= '0;
      neg       <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      state     <= state_next;
      op        <= op_next;
      a         <= a_next;
      b         <= b_next;
      result    <= result_next;
      neg       <= neg_next;
      res_valid <= res_valid_next;
    end
  end

  always_comb begin
    bus.disp_val = '0;
    case (state)
      ST_ENT_A, ST_OP_WAIT:          bus.disp_val = RES_W'(a);
      ST_ENT_B, ST_CALC, ST_DIV_RUN: bus.disp_val = RES_W'(b);
      ST_RES:                        bus.disp_val = result;
      default:                       bus.disp_val = '0;
    endcase
  end

  assign bus.disp_neg  = (state == ST_RES) && neg;
  assign bus.err       = (state == ST_ERR);
  assign bus.busy      = (state == ST_CALC) || (state == ST_DIV_RUN);
  assign bus.res_valid = res_valid;

endmodule

// File: tb/tb_calc_ctrl.sv
// Self-checking bench for calc_ctrl: directed scenarios plus random key streams vs a calculator model.
module tb_calc_ctrl;
  import calc_pkg::*;

  localparam int MAXV = 9999;
  typedef logic [RES_W+3:0] snap_t;
  typedef enum int {M_A, M_OPW, M_B, M_RES, M_ERR} mode_e;

  logic clk = 1'b0;
  logic rst;
  calc_if bus ();

  calc_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Calculator model kept at the level of the user-visible behaviour.
  mode_e m_mode;
  int    m_a, m_b, m_op, m_res;
  bit    m_neg;

  function automatic snap_t outs();
    return {bus.disp_val, bus.disp_neg, bus.err, bus.busy, bus.res_valid};
  endfunction

  function automatic snap_t pack(input int disp, input bit neg, input bit er,
                                 input bit bsy, input bit rv);
    return {RES_W'(disp), neg, er, bsy, rv};
  endfunction

  function automatic int model_disp();
    case (m_mode)
      M_A, M_OPW: return m_a;
      M_B:        return m_b;
      M_RES:      return m_res;
      default:    return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = M_A; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_neg = 0;
  endtask

  task automatic model_step(input int k, output bit eq_go);
    eq_go = 0;
    if (k == 15) begin
      model_reset();
      return;
    end
    case (m_mode)
      M_A:   if (k <= 9) begin
               if (m_a * 10 + k <= MAXV) m_a = m_a * 10 + k;
             end else if (k <= 13) begin
               m_op = k - 10; m_mode = M_OPW;
             end
      M_OPW: if (k <= 9) begin
               m_b = k; m_mode = M_B;
             end else if (k <= 13) begin
               m_op = k - 10;
             end
      M_B:   if (k <= 9) begin
               if (m_b * 10 + k <= MAXV) m_b = m_b * 10 + k;
             end else if (k == 14) begin
               eq_go = 1;
             end
      M_RES: if (k <= 9) begin
               m_a = k; m_b = 0; m_mode = M_A;
             end
`ifdef CALC_CHAIN_EN
             else if (k <= 13 && !m_neg && m_res <= MAXV) begin
               m_a = m_res; m_b = 0; m_op = k - 10; m_mode = M_OPW;
             end
`endif
      default: ;
    endcase
    if (eq_go) begin
      m_neg = 0;
      case (m_op)
        0: m_res = m_a + m_b;
        1: begin
             m_res = (m_a >= m_b) ? m_a - m_b : m_b - m_a;
             m_neg = (m_a < m_b);
           end
        2: m_res = m_a * m_b;
        default: m_res = (m_b == 0) ? 0 : m_a / m_b;
      endcase
      if (m_op == 3 && m_b == 0) m_mode = M_ERR;
      else                       m_mode = M_RES;
    end
  endtask

  // Key flag is raised for exactly one cycle; returns in the cycle after the key was taken.
  task automatic press(input int k);
    @(negedge clk);
    bus.key_flag = 1'b1;
    bus.key_data = 4'(k);
    @(negedge clk);
    bus.key_flag = 1'b0;
    bus.key_data = 4'd0;
  endtask

  // Drive one key through model and DUT and compare everything the display stage sees.
  task automatic apply_key(input int k, input string tag);
    bit    eq_go;
    int    cyc, busy_cnt;
    snap_t e;
    model_step(k, eq_go);
    press(k);
    if (!eq_go) begin
      e = pack(model_disp(), m_mode == M_RES && m_neg, m_mode == M_ERR, 0, 0);
      n_checks++;
      if (outs() !== e) begin
        n_fail++;
        $display("FAIL %s key=%0d: got disp=%0d neg/err/busy/rv=%b expected disp=%0d neg/err/busy/rv=%b",
                 tag, k, outs() >> 4, outs() & 4'hf, e >> 4, e & 4'hf);
      end
    end else begin
      n_checks++;
      if (bus.busy !== 1'b1 || bus.res_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s calc cycle: got busy=%b rv=%b expected busy=1 rv=0",
                 tag, bus.busy, bus.res_valid);
      end
      if (m_mode == M_ERR) begin
        @(negedge clk);
        e = pack(0, 0, 1, 0, 0);
      end else if (m_op != 3) begin
        @(negedge clk);
        e = pack(m_res, m_neg, 0, 0, 1);
      end else begin
        cyc = 1; busy_cnt = 0;
        while (bus.res_valid !== 1'b1 && cyc < 40) begin
          if (bus.busy === 1'b1) busy_cnt++;
          @(negedge clk);
          cyc++;
        end
        n_checks++;
        if (cyc != OP_W + 2) begin
          n_fail++;
          $display("FAIL %s div latency: got res_valid at cycle %0d expected %0d", tag, cyc, OP_W + 2);
        end
        n_checks++;
        if (busy_cnt != OP_W + 1) begin
          n_fail++;
          $display("FAIL %s div busy: got %0d cycles expected %0d", tag, busy_cnt, OP_W + 1);
        end
        e = pack(m_res, 0, 0, 0, 1);
      end
      n_checks++;
      if (outs() !== e) begin
        n_fail++;
        $display("FAIL %s result: got disp=%0d neg/err/busy/rv=%b expected disp=%0d neg/err/busy/rv=%b",
                 tag, outs() >> 4, outs() & 4'hf, e >> 4, e & 4'hf);
      end
      if (m_mode == M_RES) begin
        @(negedge clk);
        e = pack(m_res, m_neg, 0, 0, 0);
        n_checks++;
        if (outs() !== e) begin
          n_fail++;
          $display("FAIL %s res_valid pulse: got disp=%0d flags=%b expected disp=%0d flags=%b",
                   tag, outs() >> 4, outs() & 4'hf, e >> 4, e & 4'hf);
        end
      end
    end
  endtask

  task automatic apply_seq(input int keys[$], input string tag);
    foreach (keys[i]) apply_key(keys[i], tag);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.key_flag = 1'b0;
    bus.key_data = 4'd0;
    model_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (outs() !== '0) begin
      n_fail++;
      $display("FAIL reset outputs: got %h expected 0", outs());
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (outs() !== '0) begin
      n_fail++;
      $display("FAIL post-reset outputs: got %h expected 0", outs());
    end
  endtask

  task automatic test_add_sub();
    apply_seq('{15, 1, 10, 9, 14}, "add");
    n_checks++;
    if (bus.disp_val !== RES_W'(10) || bus.disp_neg !== 1'b0) begin
      n_fail++;
      $display("FAIL add 1+9: got %0d neg=%b expected 10 neg=0", bus.disp_val, bus.disp_neg);
    end
    apply_seq('{15, 1, 11, 9, 14}, "sub_neg");
    n_checks++;
    if (bus.disp_val !== RES_W'(8) || bus.disp_neg !== 1'b1) begin
      n_fail++;
      $display("FAIL sub 1-9: got %0d neg=%b expected 8 neg=1", bus.disp_val, bus.disp_neg);
    end
    apply_seq('{15, 9, 11, 1, 14}, "sub_pos");
    n_checks++;
    if (bus.disp_val !== RES_W'(8) || bus.disp_neg !== 1'b0) begin
      n_fail++;
      $display("FAIL sub 9-1: got %0d neg=%b expected 8 neg=0", bus.disp_val, bus.disp_neg);
    end
  endtask

  task automatic test_mul_limit();
    apply_seq('{15, 9, 9, 9, 9, 9, 12, 9, 9, 9, 9, 9, 14}, "mul");
    n_checks++;
    if (bus.disp_val !== RES_W'(99980001)) begin
      n_fail++;
      $display("FAIL mul 9999*9999: got %0d expected 99980001", bus.disp_val);
    end
  endtask

  task automatic test_div();
    apply_seq('{15, 9, 13, 2, 14}, "div");
    n_checks++;
    if (bus.disp_val !== RES_W'(4)) begin
      n_fail++;
      $display("FAIL div 9/2: got %0d expected 4", bus.disp_val);
    end
    apply_seq('{15, 7, 13, 0, 14, 5}, "div0");
    n_checks++;
    if (bus.err !== 1'b1 || bus.disp_val !== '0) begin
      n_fail++;
      $display("FAIL div by zero: got err=%b disp=%0d expected err=1 disp=0", bus.err, bus.disp_val);
    end
    apply_key(15, "div0_clear");
    n_checks++;
    if (bus.err !== 1'b0 || bus.disp_val !== '0) begin
      n_fail++;
      $display("FAIL clear after error: got err=%b disp=%0d expected err=0 disp=0", bus.err, bus.disp_val);
    end
  endtask

  task automatic test_ignored_keys();
    apply_seq('{15, 14, 5, 10, 12, 14, 3, 11, 10, 6, 14}, "ignored");
    n_checks++;
    if (bus.disp_val !== RES_W'(180)) begin
      n_fail++;
      $display("FAIL op overwrite 5*36: got %0d expected 180", bus.disp_val);
    end
  endtask

  task automatic test_busy_drop();
    bit eq_go;
    int cyc;
    apply_seq('{15, 8, 13, 2}, "busy_drop");
    model_step(14, eq_go);
    press(14);
    @(negedge clk);
    press(5);
    press(10);
    cyc = 0;
    while (bus.res_valid !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (bus.res_valid !== 1'b1 || bus.disp_val !== RES_W'(4)) begin
      n_fail++;
      $display("FAIL keys while busy: got rv=%b disp=%0d expected rv=1 disp=4", bus.res_valid, bus.disp_val);
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    int rv_seen;
    apply_seq('{15, 9, 13, 1}, "abort");
    press(14);
    repeat (4) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort busy before clear: got %b expected 1", bus.busy);
    end
    apply_key(15, "abort_clear");
    rv_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.res_valid === 1'b1) rv_seen++;
    end
    n_checks++;
    if (rv_seen != 0 || bus.disp_val !== '0) begin
      n_fail++;
      $display("FAIL abort: got %0d res_valid pulses disp=%0d expected 0 and 0", rv_seen, bus.disp_val);
    end
  endtask

  task automatic test_chain();
    apply_seq('{15, 2, 10, 3, 14, 12, 4, 14}, "chain");
    n_checks++;
`ifdef CALC_CHAIN_EN
    if (bus.disp_val !== RES_W'(20)) begin
      n_fail++;
      $display("FAIL chain 5*4: got %0d expected 20", bus.disp_val);
    end
`else
    if (bus.disp_val !== RES_W'(4)) begin
      n_fail++;
      $display("FAIL no chain: got %0d expected 4", bus.disp_val);
    end
`endif
  endtask

  task automatic test_rst_mid_div();
    int rv_seen;
    apply_seq('{15, 9, 13, 1}, "rst_div");
    press(14);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (outs() !== '0) begin
      n_fail++;
      $display("FAIL async reset mid-divide: got %h expected 0", outs());
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    apply_key(14, "rst_div_eq");
    rv_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.res_valid === 1'b1) rv_seen++;
    end
    n_checks++;
    if (rv_seen != 0) begin
      n_fail++;
      $display("FAIL stale result after reset: got %0d res_valid pulses expected 0", rv_seen);
    end
  endtask

  task automatic test_random();
    int r, k;
    apply_key(15, "rand");
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 55)      k = int'($urandom_range(0, 9));
      else if (r < 75) k = int'($urandom_range(10, 13));
      else if (r < 93) k = 14;
      else             k = 15;
      apply_key(k, "rand");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add_sub();
    test_mul_limit();
    test_div();
    test_ignored_keys();
    test_busy_drop();
    test_abort();
    test_chain();
    test_rst_mid_div();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
